id_branch_stage: RTL and testbench
==================================

Name: id_branch_stage

Overview:
- Parametrised decode stage for the MIPS pipeline. It takes one fetched instruction per handshake, extends the immediate, and resolves all branches and jumps in ID. It also fills in link writeback for jal/jalr and ages the producer tnew field.
- Results are held in a single-entry ID/EX pipeline register with a valid/ready handshake and flush.
- It extends the old combinational decoder with full branch coverage, lui/logical extension, back-pressure, optional delay-slot squash and a data-width parameter.

Parameters:
- XLEN, 32, width of PC, operand and writeback data (>=32).
- TNEW_W, 4, width of the tnew field.
- DELAY_SLOT, 1, 1 = the instruction after a taken control transfer executes; 0 = it is squashed.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the held entry and the squash state.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  PC of the instruction.
- in_rs_val  in  XLEN  forwarded GPR[rs].
- in_rt_val  in  XLEN  forwarded GPR[rt].
- in_tnew  in  TNEW_W  cycles until the result is ready.
- in_a3  in  5  writeback register.
- in_wd  in  XLEN  writeback data.
- in_we  in  1  writeback enable.
- out_valid  out  1  held entry valid.
- out_ready  in  1  EX accepts.
- out_instr, out_pc, out_rs_val, out_rt_val, out_a3, out_wd, out_we  out  as inputs  registered copies, with link overrides applied.
- out_ext  out  XLEN  extended immediate.
- out_tnew  out  TNEW_W  aged tnew.
- redirect_valid  out  1  control transfer taken this cycle.
- redirect_pc  out  XLEN  target PC.

Behaviour:
- Reset (async, reset_n=0): out_valid=0, all out_* data=0, state=NORMAL. redirect_valid=0 because nothing is accepted.
- in_ready = !flush && (!out_valid || out_ready). Define accept = in_valid && in_ready.
- Register update, by priority:
  - flush: out_valid<=0, state<=NORMAL.
  - accept and not squashed: load all out_*, out_valid<=1.
  - accept and squashed: out_valid<=0, data don't-care.
  - out_ready and out_valid with no accept: out_valid<=0.
  - otherwise hold all outputs.
- Latency: 1 cycle from accept to out_valid.
- Extension:
  - ori/andi/xori (opcodes 0x0D/0x0C/0x0E): zero-extend imm16.
  - lui (0x0F): {imm16, 16'h0}, sign-extended to XLEN.
  - all other opcodes: sign-extend imm16 to XLEN.
- Branch conditions (signed compare, XLEN wide):
  - beq 0x04: rs==rt.
  - bne 0x05: rs!=rt.
  - blez 0x06: rs<=0.
  - bgtz 0x07: rs>0.
  - REGIMM 0x01: rt field 0 = bltz, rs<0; rt field 1 = bgez, rs>=0; any other rt field = not taken.
  - Target = PC+4 + (ext<<2), using the sign-extended imm16 and modulo 2^XLEN.
- Jumps:
  - j 0x02 / jal 0x03: target {(PC+4)[XLEN-1:28], instr[25:0], 2'b00}.
  - jr (opcode 0, funct 0x08) and jalr (opcode 0, funct 0x09): target rs_val.
- redirect_valid = accept && taken && state!=SQUASH. It is combinational in the accept cycle. redirect_pc is 0 when redirect_valid=0.
- Link overrides:
  - jal: out_a3=31, out_wd=PC+8, out_we=1.
  - jalr: out_a3=instr[15:11], out_wd=PC+8, out_we=1.
  - All other instructions pass in_a3/in_wd/in_we through unchanged.
- tnew: out_tnew = in_tnew==0 ? 0 : in_tnew-1 (saturating).
- FSM, only when DELAY_SLOT=0:
  - NORMAL: on a redirect, go to SQUASH.
  - SQUASH: the next accepted instruction is dropped and produces no redirect even if it is a branch; then go to NORMAL.
  - flush forces NORMAL.
  - While no instruction is accepted, the FSM stays in SQUASH.
- With DELAY_SLOT=1 the state is always NORMAL.
- Redirect and flush in the same cycle cannot both happen, because flush forces in_ready=0.
- Unknown opcodes: no redirect, sign-extend, fields pass through.

Test Plan:
- Reset with reset_n=0 mid-transfer -> out_valid=0 immediately, asynchronously; out_tnew=0; the first accept after release appears 1 cycle later.
- beq, PC=0x3000, imm=0xFFFF, rs=rt=5 -> redirect_valid=1 and redirect_pc=0x3000 in the accept cycle. Repeat with rs=5, rt=6 -> redirect_valid=0.
- bgez with rs=0xFFFFFFFF, then bltz with the same rs -> not taken, then taken. ori with imm 0x8001 -> out_ext=0x00008001. lui with imm 0x8001 -> out_ext=0x80010000.
- jal at PC=0x3010, instr[25:0]=0x0000C10 -> redirect_pc=0x00003040, out_a3=31, out_wd=0x3018, out_we=1. jalr with rd=7, rs=0x3100 -> redirect_pc=0x3100, out_a3=7.
- Back-pressure: out_ready=0 while out_valid=1 -> in_ready=0 and outputs stable for 3 cycles. Raise out_ready -> next instruction loads. Assert flush -> out_valid=0 the next cycle.
- DELAY_SLOT=0: a taken bne followed by a taken beq -> only the first redirects; out_valid stays 0 for the second; the third instruction is accepted normally. Also check in_tnew=3 -> out_tnew=2, and in_tnew=0 -> out_tnew=0.

Source files
------------

// File: rtl/id_branch_stage.sv
// MIPS decode stage: immediate extension, branch/jump resolution and link fill-in,
// with results held in a single-entry ID/EX register behind a valid/ready handshake.
module id_branch_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TNEW_W     = 4,
  parameter int unsigned DELAY_SLOT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs_val,
  input  logic [XLEN-1:0]   in_rt_val,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [4:0]        in_a3,
  input  logic [XLEN-1:0]   in_wd,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs_val,
  output logic [XLEN-1:0]   out_rt_val,
  output logic [4:0]        out_a3,
  output logic [XLEN-1:0]   out_wd,
  output logic              out_we,
  output logic [XLEN-1:0]   out_ext,
  output logic [TNEW_W-1:0] out_tnew,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc
);

  typedef enum logic [0:0] {StNormal, StSquash} state_e;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpRegimm  = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpBlez    = 6'h06;
  localparam logic [5:0] OpBgtz    = 6'h07;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] FnJr      = 6'h08;
  localparam logic [5:0] FnJalr    = 6'h09;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rs_val_q, rs_val_d;
  logic [XLEN-1:0]   rt_val_q, rt_val_d;
  logic [4:0]        a3_q, a3_d;
  logic [XLEN-1:0]   wd_q, wd_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   ext_q, ext_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;

  logic [5:0]      opcode, funct;
  logic [4:0]      rt_f, rd_f;
  logic [15:0]     imm16;
  logic [XLEN-1:0] sext, pc4, pc8, br_target, j_target, target, ext;
  logic            taken, link, accept, squashed, rs_neg, rs_zero;
  logic [4:0]      link_a3;

  assign opcode = in_instr[31:26];
  assign rt_f   = in_instr[20:16];
  assign rd_f   = in_instr[15:11];
  assign funct  = in_instr[5:0];
  assign imm16  = in_instr[15:0];

  assign sext      = XLEN'($signed(imm16));
  assign pc4       = in_pc + XLEN'(4);
  assign pc8       = in_pc + XLEN'(8);
  assign br_target = pc4 + (sext << 2);
  assign j_target  = {pc4[XLEN-1:28], in_instr[25:0], 2'b00};
  assign rs_neg    = in_rs_val[XLEN-1];
  assign rs_zero   = (in_rs_val == '0);

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign squashed = (state_q == StSquash);

  always_comb begin
    taken   = 1'b0;
    target  = br_target;
    link    = 1'b0;
    link_a3 = 5'd31;
    ext     = sext;
    case (opcode)
      OpBeq:    taken = (in_rs_val == in_rt_val);
      OpBne:    taken = (in_rs_val != in_rt_val);
      OpBlez:   taken = rs_neg || rs_zero;
      OpBgtz:   taken = !rs_neg && !rs_zero;
      OpRegimm: begin
        if (rt_f == 5'd0)      taken = rs_neg;
        else if (rt_f == 5'd1) taken = !rs_neg;
      end
      OpJ: begin
        taken  = 1'b1;
        target = j_target;
      end
      OpJal: begin
        taken  = 1'b1;
        target = j_target;
        link   = 1'b1;
      end
      OpSpecial: begin
        if (funct == FnJr || funct == FnJalr) begin
          taken  = 1'b1;
          target = in_rs_val;
        end
        if (funct == FnJalr) begin
          link    = 1'b1;
          link_a3 = rd_f;
        end
      end
      OpAndi, OpOri, OpXori: ext = XLEN'(imm16);
      OpLui:                 ext = XLEN'($signed({imm16, 16'h0000}));
      default: ;
    endcase
  end

  assign redirect_valid = accept && taken && !squashed;
  assign redirect_pc    = redirect_valid ? target : '0;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    rs_val_d = rs_val_q;
    rt_val_d = rt_val_q;
    a3_d     = a3_q;
    wd_d     = wd_q;
    we_d     = we_q;
    ext_d    = ext_q;
    tnew_d   = tnew_q;
    if (flush) begin
      valid_d = 1'b0;
      state_d = StNormal;
    end else if (accept && !squashed) begin
      valid_d  = 1'b1;
      instr_d  = in_instr;
      pc_d     = in_pc;
      rs_val_d = in_rs_val;
      rt_val_d = in_rt_val;
      a3_d     = link ? link_a3 : in_a3;
      wd_d     = link ? pc8 : in_wd;
      we_d     = link ? 1'b1 : in_we;
      ext_d    = ext;
      tnew_d   = (in_tnew == '0) ? '0 : in_tnew - TNEW_W'(1);
      if (taken && DELAY_SLOT == 0) state_d = StSquash;
    end else if (accept) begin
      // Dropped delay-slot instruction: consumes the squash, leaves no entry.
      valid_d = 1'b0;
      state_d = StNormal;
    end else if (out_ready && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StNormal;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      a3_q     <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      ext_q    <= '0;
      tnew_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      rs_val_q <= rs_val_d;
      rt_val_q <= rt_val_d;
      a3_q     <= a3_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      ext_q    <= ext_d;
      tnew_q   <= tnew_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_instr  = instr_q;
  assign out_pc     = pc_q;
  assign out_rs_val = rs_val_q;
  assign out_rt_val = rt_val_q;
  assign out_a3     = a3_q;
  assign out_wd     = wd_q;
  assign out_we     = we_q;
  assign out_ext    = ext_q;
  assign out_tnew   = tnew_q;

endmodule

// File: tb/tb_id_branch_stage.sv
// Directed bench for id_branch_stage: one instance with delay slots, one with squash.
module tb_id_branch_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs_val = '0, in_rt_val = '0, in_wd = '0;
  logic [3:0]  in_tnew = '0;
  logic [4:0]  in_a3 = '0;
  logic        in_we = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_we, redirect_valid;
  logic [31:0] out_instr, out_pc, out_rs_val, out_rt_val, out_wd, out_ext, redirect_pc;
  logic [4:0]  out_a3;
  logic [3:0]  out_tnew;

  logic        d0_in_ready, d0_out_valid, d0_out_we, d0_redirect_valid;
  logic [31:0] d0_out_instr, d0_out_pc, d0_out_rs_val, d0_out_rt_val, d0_out_wd, d0_out_ext;
  logic [31:0] d0_redirect_pc;
  logic [4:0]  d0_out_a3;
  logic [3:0]  d0_out_tnew;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_branch_stage #(.XLEN(32), .TNEW_W(4), .DELAY_SLOT(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_tnew(in_tnew), .in_a3(in_a3), .in_wd(in_wd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val), .out_a3(out_a3), .out_wd(out_wd),
    .out_we(out_we), .out_ext(out_ext), .out_tnew(out_tnew),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  id_branch_stage #(.XLEN(32), .TNEW_W(4), .DELAY_SLOT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(d0_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
    .in_tnew(in_tnew), .in_a3(in_a3), .in_wd(in_wd), .in_we(in_we),
    .out_valid(d0_out_valid), .out_ready(out_ready), .out_instr(d0_out_instr),
    .out_pc(d0_out_pc), .out_rs_val(d0_out_rs_val), .out_rt_val(d0_out_rt_val),
    .out_a3(d0_out_a3), .out_wd(d0_out_wd), .out_we(d0_out_we), .out_ext(d0_out_ext),
    .out_tnew(d0_out_tnew), .redirect_valid(d0_redirect_valid), .redirect_pc(d0_redirect_pc)
  );

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Presents one instruction half a cycle before the sampling edge.
  task automatic set_in(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt, input logic [3:0] tnew,
                        input logic [4:0] a3, input logic [31:0] wd, input logic we);
    @(negedge clk);
    in_instr = instr; in_pc = pc; in_rs_val = rs; in_rt_val = rt;
    in_tnew = tnew; in_a3 = a3; in_wd = wd; in_we = we;
    in_valid = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_tnew !== 4'd0) begin n_fail++; $display("FAIL rst_tnew got %0d want 0", out_tnew); end
    @(negedge clk); reset_n = 1'b1;
    set_in(itype(6'h09, 5'd1, 5'd2, 16'h0004), 32'h100, 0, 0, 4'd5, 5'd2, 32'h55, 1'b1);
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid got %0b want 1", out_valid); end
    n_cmp++; if (out_tnew !== 4'd4) begin n_fail++; $display("FAIL pre_rst_tnew got %0d want 4", out_tnew); end
    #2; reset_n = 1'b0; #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_tnew !== 4'd0) begin n_fail++; $display("FAIL async_rst_tnew got %0d want 0", out_tnew); end
    @(negedge clk); reset_n = 1'b1;
    set_in(itype(6'h09, 5'd1, 5'd2, 16'h0008), 32'h200, 0, 0, 4'd1, 5'd2, 32'h0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_early got %0b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      n_fail++; $display("FAIL post_rst_load got v=%0b pc=%h want v=1 pc=00000200", out_valid, out_pc);
    end
  endtask

  task automatic test_branch();
    set_in(itype(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h3000, 5, 5, 4'd0, 5'd0, 0, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3000) begin
      n_fail++; $display("FAIL beq_taken got v=%0b pc=%h want v=1 pc=00003000", redirect_valid, redirect_pc);
    end
    step();
    set_in(itype(6'h04, 5'd1, 5'd2, 16'hFFFF), 32'h3000, 5, 6, 4'd0, 5'd0, 0, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL beq_not got v=%0b pc=%h want v=0 pc=0", redirect_valid, redirect_pc);
    end
    step();
    set_in(itype(6'h01, 5'd3, 5'd1, 16'h0010), 32'h4000, 32'hFFFFFFFF, 0, 4'd0, 5'd0, 0, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bgez_neg got %0b want 0", redirect_valid); end
    step();
    set_in(itype(6'h01, 5'd3, 5'd0, 16'h0010), 32'h4000, 32'hFFFFFFFF, 0, 4'd0, 5'd0, 0, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4044) begin
      n_fail++; $display("FAIL bltz_neg got v=%0b pc=%h want v=1 pc=00004044", redirect_valid, redirect_pc);
    end
    step();
    set_in(itype(6'h07, 5'd3, 5'd0, 16'h0002), 32'h4100, 32'h0, 0, 4'd0, 5'd0, 0, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL bgtz_zero got %0b want 0", redirect_valid); end
    step();
    set_in(itype(6'h06, 5'd3, 5'd0, 16'h0002), 32'h4100, 32'h0, 0, 4'd0, 5'd0, 0, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h410C) begin
      n_fail++; $display("FAIL blez_zero got v=%0b pc=%h want v=1 pc=0000410c", redirect_valid, redirect_pc);
    end
    step();
  endtask

  task automatic test_ext();
    set_in(itype(6'h0D, 5'd1, 5'd2, 16'h8001), 32'h500, 0, 0, 4'd2, 5'd3, 32'hABC, 1'b0);
    step();
    n_cmp++; if (out_ext !== 32'h00008001) begin n_fail++; $display("FAIL ori_ext got %h want 00008001", out_ext); end
    n_cmp++; if (out_a3 !== 5'd3 || out_wd !== 32'hABC || out_we !== 1'b0) begin
      n_fail++; $display("FAIL ori_pass got a3=%0d wd=%h we=%0b want a3=3 wd=00000abc we=0", out_a3, out_wd, out_we);
    end
    set_in(itype(6'h0F, 5'd0, 5'd2, 16'h8001), 32'h504, 0, 0, 4'd0, 5'd2, 0, 1'b1);
    step();
    n_cmp++; if (out_ext !== 32'h80010000) begin n_fail++; $display("FAIL lui_ext got %h want 80010000", out_ext); end
    set_in(itype(6'h09, 5'd0, 5'd2, 16'h8001), 32'h508, 0, 0, 4'd0, 5'd2, 0, 1'b1);
    step();
    n_cmp++; if (out_ext !== 32'hFFFF8001) begin n_fail++; $display("FAIL addiu_ext got %h want ffff8001", out_ext); end
  endtask

  task automatic test_jump();
    set_in({6'h03, 26'h0000C10}, 32'h3010, 0, 0, 4'd1, 5'd4, 32'h1, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3040) begin
      n_fail++; $display("FAIL jal_redirect got v=%0b pc=%h want v=1 pc=00003040", redirect_valid, redirect_pc);
    end
    step();
    n_cmp++; if (out_a3 !== 5'd31 || out_wd !== 32'h3018 || out_we !== 1'b1) begin
      n_fail++; $display("FAIL jal_link got a3=%0d wd=%h we=%0b want a3=31 wd=00003018 we=1", out_a3, out_wd, out_we);
    end
    set_in({6'h00, 5'd1, 5'd0, 5'd7, 5'd0, 6'h09}, 32'h3020, 32'h3100, 0, 4'd0, 5'd9, 32'h1, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h3100) begin
      n_fail++; $display("FAIL jalr_redirect got v=%0b pc=%h want v=1 pc=00003100", redirect_valid, redirect_pc);
    end
    step();
    n_cmp++; if (out_a3 !== 5'd7 || out_wd !== 32'h3028 || out_we !== 1'b1) begin
      n_fail++; $display("FAIL jalr_link got a3=%0d wd=%h we=%0b want a3=7 wd=00003028 we=1", out_a3, out_wd, out_we);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] a, b;
    a = itype(6'h09, 5'd1, 5'd2, 16'h1234);
    b = itype(6'h09, 5'd1, 5'd2, 16'h5678);
    set_in(a, 32'h600, 0, 0, 4'd0, 5'd2, 0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_instr = b; in_pc = 32'h604; in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %0b want 0", i, in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_instr !== a) begin
        n_fail++; $display("FAIL bp_hold[%0d] got v=%0b instr=%h want v=1 instr=%h", i, out_valid, out_instr, a);
      end
    end
    @(negedge clk);
    out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %0b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== b) begin
      n_fail++; $display("FAIL bp_next got v=%0b instr=%h want v=1 instr=%h", out_valid, out_instr, b);
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0b want 0", in_ready); end
    step();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || d0_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_valid got %0b/%0b want 0/0", out_valid, d0_out_valid);
    end
  endtask

  task automatic test_squash();
    logic [31:0] third;
    third = itype(6'h09, 5'd1, 5'd2, 16'h0042);
    set_in(itype(6'h05, 5'd1, 5'd2, 16'h0004), 32'h5000, 1, 2, 4'd3, 5'd0, 0, 1'b0);
    n_cmp++; if (d0_redirect_valid !== 1'b1 || d0_redirect_pc !== 32'h5014) begin
      n_fail++; $display("FAIL ds0_bne got v=%0b pc=%h want v=1 pc=00005014", d0_redirect_valid, d0_redirect_pc);
    end
    step();
    n_cmp++; if (d0_out_valid !== 1'b1 || d0_out_tnew !== 4'd2) begin
      n_fail++; $display("FAIL ds0_bne_out got v=%0b tnew=%0d want v=1 tnew=2", d0_out_valid, d0_out_tnew);
    end
    set_in(itype(6'h04, 5'd1, 5'd2, 16'h0008), 32'h5004, 7, 7, 4'd0, 5'd0, 0, 1'b0);
    n_cmp++; if (d0_redirect_valid !== 1'b0 || d0_redirect_pc !== 32'h0) begin
      n_fail++; $display("FAIL ds0_slot_redirect got v=%0b pc=%h want v=0 pc=0", d0_redirect_valid, d0_redirect_pc);
    end
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h5028) begin
      n_fail++; $display("FAIL ds1_slot_redirect got v=%0b pc=%h want v=1 pc=00005028", redirect_valid, redirect_pc);
    end
    step();
    n_cmp++; if (d0_out_valid !== 1'b0) begin n_fail++; $display("FAIL ds0_slot_valid got %0b want 0", d0_out_valid); end
    set_in(third, 32'h5008, 0, 0, 4'd0, 5'd2, 0, 1'b1);
    n_cmp++; if (d0_in_ready !== 1'b1 || d0_redirect_valid !== 1'b0) begin
      n_fail++; $display("FAIL ds0_third_in got rdy=%0b redir=%0b want rdy=1 redir=0", d0_in_ready, d0_redirect_valid);
    end
    step();
    n_cmp++; if (d0_out_valid !== 1'b1 || d0_out_instr !== third || d0_out_tnew !== 4'd0) begin
      n_fail++; $display("FAIL ds0_third got v=%0b instr=%h tnew=%0d want v=1 instr=%h tnew=0",
                         d0_out_valid, d0_out_instr, d0_out_tnew, third);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_ext();
    test_jump();
    test_back_pressure();
    test_squash();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
